// File: rtl/axis_block_averager.sv
// -----------------------------------------------------------------------------
// axis_block_averager
//
// Purpose:
//   Reduces a continuous multi-lane sample stream to a lower rate. For each
//   lane it sums 2^L consecutive accepted samples and emits the arithmetic
//   mean (floor toward -inf) as one AXI-Stream word per block. The source
//   cannot be stalled, so the output is a single holding register. A result
//   that arrives while that register is full and not being accepted is
//   dropped and counted.
//
// Ports:
//   aclk           in   1              clock, rising edge
//   aresetn        in   1              asynchronous active-low reset
//   enable         in   1              run control (IDLE <-> RUN)
//   log_throttle   in   5              log2 block length, latched on IDLE->RUN
//   S_AXIS_tvalid  in   1              input sample valid
//   S_AXIS_tdata   in   LANES*LANE_W   input samples, lane0 in the low bits
//   S_AXIS_tready  out  1              0 in reset, 1 from the first clock after
//   M_AXIS_tvalid  out  1              averaged word valid
//   M_AXIS_tdata   out  LANES*LANE_W   averaged samples
//   M_AXIS_tready  in   1              downstream accept
//   dropped_count  out  16             results lost to back-pressure (saturating)
//   overflow       out  1              sticky flag, set on any drop
//   o_dbg_state    out  1              FSM state (0 = IDLE, 1 = RUN)
//
// Handshake: a word transfers on M_AXIS in any cycle where M_AXIS_tvalid and
// M_AXIS_tready are both 1 at the rising clock edge. Once M_AXIS_tvalid is
// asserted, M_AXIS_tdata holds steady until that transfer. S_AXIS is always
// ready after reset, so every S_AXIS_tvalid cycle delivers a sample.
// -----------------------------------------------------------------------------
module axis_block_averager #(
  parameter int LANES   = 2,
  parameter int LANE_W  = 16,
  parameter int MAX_LOG = 16
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      enable,
  input  logic [4:0]                log_throttle,
  input  logic                      S_AXIS_tvalid,
  input  logic [LANES*LANE_W-1:0]   S_AXIS_tdata,
  output logic                      S_AXIS_tready,
  output logic                      M_AXIS_tvalid,
  output logic [LANES*LANE_W-1:0]   M_AXIS_tdata,
  input  logic                      M_AXIS_tready,
  output logic [15:0]               dropped_count,
  output logic                      overflow,
  output logic                      o_dbg_state
);

  localparam int ACC_W = LANE_W + MAX_LOG;
  localparam int CNT_W = MAX_LOG;
  localparam logic [MAX_LOG:0] ONE_L = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                      r_state;
  state_t                      w_state_next;
  logic [4:0]                  r_log;
  logic [CNT_W-1:0]            r_count;
  logic signed [ACC_W-1:0]     r_acc [LANES];
  logic                        r_s_tready;
  logic                        r_m_tvalid;
  logic [LANES*LANE_W-1:0]     r_m_tdata;
  logic [15:0]                 r_dropped;
  logic                        r_overflow;

  logic [4:0]                  w_log_sat;
  logic                        w_start;
  logic                        w_stop;
  logic                        w_accept;
  logic [MAX_LOG:0]            w_blk_len;
  logic                        w_last;
  logic                        w_new_result;
  logic                        w_handshake;
  logic signed [ACC_W-1:0]     w_sum [LANES];
  logic [LANES*LANE_W-1:0]     w_result;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_stop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (enable) begin
          w_state_next = ST_RUN;
          w_start      = 1'b1;
        end
      end
      ST_RUN: begin
        if (!enable) begin
          w_state_next = ST_IDLE;
          w_stop       = 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Accumulate / block completion
  // ---------------------------------------------------------------------------
  // Requests beyond MAX_LOG saturate; the accumulator is sized for MAX_LOG.
  assign w_log_sat = (log_throttle > 5'(MAX_LOG)) ? 5'(MAX_LOG) : log_throttle;

  // Samples count only while running and enabled; the cycle that drops
  // enable already belongs to the stop and contributes nothing.
  assign w_accept     = (r_state == ST_RUN) && enable && S_AXIS_tvalid;
  assign w_blk_len    = ONE_L << r_log;
  assign w_last       = ({1'b0, r_count} == (w_blk_len - ONE_L));
  assign w_new_result = w_accept && w_last;
  assign w_handshake  = r_m_tvalid && M_AXIS_tready;

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      w_sum[l] = r_acc[l] + {{MAX_LOG{S_AXIS_tdata[l*LANE_W + LANE_W - 1]}},
                             S_AXIS_tdata[l*LANE_W +: LANE_W]};
      // Arithmetic shift on the full-width signed sum, then truncate.
      w_result[l*LANE_W +: LANE_W] = LANE_W'(w_sum[l] >>> r_log);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_log   <= '0;
      r_count <= '0;
      for (int l = 0; l < LANES; l++) r_acc[l] <= '0;
    end else begin
      if (w_start) begin
        r_log   <= w_log_sat;
        r_count <= '0;
        for (int l = 0; l < LANES; l++) r_acc[l] <= '0;
      end else if (w_stop) begin
        r_count <= '0;
        for (int l = 0; l < LANES; l++) r_acc[l] <= '0;
      end else if (w_accept) begin
        if (w_last) begin
          r_count <= '0;
          for (int l = 0; l < LANES; l++) r_acc[l] <= '0;
        end else begin
          r_count <= r_count + CNT_W'(1);
          for (int l = 0; l < LANES; l++) r_acc[l] <= w_sum[l];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output holding register and drop accounting
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_s_tready <= 1'b0;
      r_m_tvalid <= 1'b0;
      r_m_tdata  <= '0;
      r_dropped  <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_s_tready <= 1'b1;

      if (w_new_result) begin
        if (!r_m_tvalid || M_AXIS_tready) begin
          r_m_tvalid <= 1'b1;
          r_m_tdata  <= w_result;
        end else begin
          // Held word is still waiting; the fresh result is lost.
          r_overflow <= 1'b1;
          if (r_dropped != 16'hFFFF) r_dropped <= r_dropped + 16'd1;
        end
      end else if (w_handshake) begin
        r_m_tvalid <= 1'b0;
      end

      // Drop statistics restart with each new run. No result can be produced
      // in the start cycle, so this never collides with the drop update above.
      if (w_start) begin
        r_dropped  <= '0;
        r_overflow <= 1'b0;
      end
    end
  end

  assign S_AXIS_tready = r_s_tready;
  assign M_AXIS_tvalid = r_m_tvalid;
  assign M_AXIS_tdata  = r_m_tdata;
  assign dropped_count = r_dropped;
  assign overflow      = r_overflow;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_axis_block_averager.sv
// -----------------------------------------------------------------------------
// Directed bench for axis_block_averager. Inputs change 1 ns after the rising
// edge; outputs are checked at the same point, so each check sees the result
// of the edge that consumed the preceding inputs.
// -----------------------------------------------------------------------------
module tb_axis_block_averager;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        enable;
  logic [4:0]  log_throttle;
  logic        S_AXIS_tvalid;
  logic [31:0] S_AXIS_tdata;
  logic        S_AXIS_tready;
  logic        M_AXIS_tvalid;
  logic [31:0] M_AXIS_tdata;
  logic        M_AXIS_tready;
  logic [15:0] dropped_count;
  logic        overflow;
  logic        o_dbg_state;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 aclk = ~aclk;

  axis_block_averager dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .enable        (enable),
    .log_throttle  (log_throttle),
    .S_AXIS_tvalid (S_AXIS_tvalid),
    .S_AXIS_tdata  (S_AXIS_tdata),
    .S_AXIS_tready (S_AXIS_tready),
    .M_AXIS_tvalid (M_AXIS_tvalid),
    .M_AXIS_tdata  (M_AXIS_tdata),
    .M_AXIS_tready (M_AXIS_tready),
    .dropped_count (dropped_count),
    .overflow      (overflow),
    .o_dbg_state   (o_dbg_state)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic put(input logic v, input logic [15:0] l1, input logic [15:0] l0);
    S_AXIS_tvalid = v;
    S_AXIS_tdata  = {l1, l0};
    tick();
  endtask

  logic [15:0] t2_l0 [4];
  logic [15:0] t2_l1 [4];
  int          n_early;

  initial begin
    t2_l0 = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    t2_l1 = '{16'hFFFF, 16'hFFFE, 16'hFFFD, 16'hFFFC};

    // ---------------- reset ----------------
    aresetn       = 1'b0;
    enable        = 1'b0;
    log_throttle  = 5'd0;
    S_AXIS_tvalid = 1'b0;
    S_AXIS_tdata  = '0;
    M_AXIS_tready = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    check("rst_tvalid",  M_AXIS_tvalid, 1'b0);
    check("rst_tdata",   M_AXIS_tdata, 32'h0);
    check("rst_tready",  S_AXIS_tready, 1'b0);
    check("rst_dropped", dropped_count, 16'h0);
    check("rst_ovf",     overflow, 1'b0);
    check("rst_state",   o_dbg_state, 1'b0);
    aresetn = 1'b1;
    tick();
    check("tready_after_rst", S_AXIS_tready, 1'b1);

    // ---------------- 1: L=0 passthrough ----------------
    enable = 1'b1;
    tick();
    check("t1_state_run", o_dbg_state, 1'b1);
    for (int i = 0; i < 8; i++) begin
      put(1'b1, 16'(i + 256), 16'(i));
      check("t1_valid", M_AXIS_tvalid, 1'b1);
      check("t1_data",  M_AXIS_tdata, {16'(i + 256), 16'(i)});
    end
    put(1'b0, 16'h0, 16'h0);
    check("t1_drain",   M_AXIS_tvalid, 1'b0);
    check("t1_dropped", dropped_count, 16'h0);

    // ---------------- 2: L=2 single block ----------------
    enable = 1'b0;
    tick();
    log_throttle = 5'd2;
    enable       = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      put(1'b1, t2_l1[k], t2_l0[k]);
      check("t2_valid", M_AXIS_tvalid, (k == 3));
    end
    check("t2_data", M_AXIS_tdata, 32'hFFFD_0002);
    put(1'b0, 16'h0, 16'h0);
    check("t2_drain", M_AXIS_tvalid, 1'b0);

    // ---------------- 3: L=2 with gapped tvalid ----------------
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) put(1'b1, t2_l1[k/2], t2_l0[k/2]);
      else            put(1'b0, 16'h0, 16'h0);
      check("t3_valid", M_AXIS_tvalid, (k == 6));
      if (k == 6) check("t3_data", M_AXIS_tdata, 32'hFFFD_0002);
    end

    // ---------------- 4: L=1 back-pressure ----------------
    enable = 1'b0;
    tick();
    log_throttle = 5'd1;
    enable       = 1'b1;
    tick();
    M_AXIS_tready = 1'b0;
    for (int j = 0; j < 10; j++) begin
      put(1'b1, 16'h0010, 16'(2 * j));
      check("t4_valid", M_AXIS_tvalid, (j >= 1));
      if (j >= 1) check("t4_held", M_AXIS_tdata, 32'h0010_0001);
    end
    check("t4_dropped", dropped_count, 16'd4);
    check("t4_ovf",     overflow, 1'b1);
    M_AXIS_tready = 1'b1;
    put(1'b1, 16'h0010, 16'd20);
    check("t4_accepted", M_AXIS_tvalid, 1'b0);
    put(1'b1, 16'h0010, 16'd22);
    check("t4_next_valid", M_AXIS_tvalid, 1'b1);
    check("t4_next_data",  M_AXIS_tdata, 32'h0010_0015);
    put(1'b0, 16'h0, 16'h0);
    check("t4_drain",      M_AXIS_tvalid, 1'b0);
    check("t4_dropped_end", dropped_count, 16'd4);

    // ---------------- 5: saturated L=16, log_throttle changed mid-run ----------
    enable = 1'b0;
    tick();
    check("t5_idle_drop_hold", dropped_count, 16'd4);
    check("t5_idle_ovf_hold",  overflow, 1'b1);
    log_throttle = 5'd31;
    enable       = 1'b1;
    tick();
    check("t5_drop_cleared", dropped_count, 16'd0);
    check("t5_ovf_cleared",  overflow, 1'b0);
    n_early = 0;
    for (int i = 0; i < 65536; i++) begin
      if (i == 100) log_throttle = 5'd0;
      put(1'b1, 16'h7FFF, 16'h7FFF);
      if (i < 65535 && M_AXIS_tvalid) n_early++;
    end
    check("t5_no_early_out", n_early, 0);
    check("t5_valid", M_AXIS_tvalid, 1'b1);
    check("t5_data",  M_AXIS_tdata, 32'h7FFF_7FFF);
    put(1'b0, 16'h0, 16'h0);
    check("t5_drain", M_AXIS_tvalid, 1'b0);

    // ---------------- 6: enable drop mid-block, then async reset ----------------
    enable = 1'b0;
    tick();
    log_throttle = 5'd3;
    enable       = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) put(1'b1, 16'd100, 16'd100);
    enable = 1'b0;
    put(1'b0, 16'h0, 16'h0);
    check("t6_state_idle", o_dbg_state, 1'b0);
    enable = 1'b1;
    put(1'b0, 16'h0, 16'h0);
    for (int k = 0; k < 8; k++) begin
      put(1'b1, 16'hFFF8, 16'(k));
      check("t6_valid", M_AXIS_tvalid, (k == 7));
    end
    check("t6_data", M_AXIS_tdata, 32'hFFF8_0003);
    M_AXIS_tready = 1'b0;
    for (int k = 0; k < 3; k++) put(1'b1, 16'd5, 16'd5);
    check("t6_held_before_rst", M_AXIS_tvalid, 1'b1);
    #2;
    aresetn = 1'b0;
    enable  = 1'b0;
    #1;
    check("t6_async_tvalid", M_AXIS_tvalid, 1'b0);
    check("t6_async_tdata",  M_AXIS_tdata, 32'h0);
    check("t6_async_tready", S_AXIS_tready, 1'b0);
    check("t6_async_state",  o_dbg_state, 1'b0);
    check("t6_async_drop",   dropped_count, 16'h0);
    tick();
    aresetn       = 1'b1;
    M_AXIS_tready = 1'b1;
    S_AXIS_tvalid = 1'b0;
    tick();
    enable = 1'b1;
    tick();
    for (int k = 0; k < 8; k++) begin
      put(1'b1, 16'hFFFC, 16'h0004);
      check("t6_post_rst_valid", M_AXIS_tvalid, (k == 7));
    end
    check("t6_post_rst_data", M_AXIS_tdata, 32'hFFFC_0004);
    put(1'b0, 16'h0, 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
